// File: rtl/l1_port_arbiter.sv
// Arbitrates the single L1 request port between instruction fetch (read-only) and the
// data-memory stage, one transaction outstanding. Optional IF starvation guard: ARB_STARVE_GUARD_EN.
module l1_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [1:0]  dm_write_type,
    input  logic [31:0] dm_write_data,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic        l1_read,
    output logic        l1_write,
    output logic [31:0] l1_addr,
    output logic [1:0]  l1_write_type,
    output logic [31:0] l1_write_data,
    input  logic        l1_ready,
    input  logic        l1_resp_valid,
    input  logic [31:0] l1_resp_data
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("l1_port_arbiter: STARVE_LIMIT must be within 1..255");
    end

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic        if_gnt_q, if_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        dm_gnt_q, dm_gnt_d;
    logic        dm_rvalid_q, dm_rvalid_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        dm_err_q, dm_err_d;
    logic        l1_read_q, l1_read_d;
    logic        l1_write_q, l1_write_d;
    logic [31:0] l1_addr_q, l1_addr_d;
    logic [1:0]  l1_write_type_q, l1_write_type_d;
    logic [31:0] l1_write_data_q, l1_write_data_d;

    logic dm_pending;
    logic dm_illegal;
    logic starve_force;
    logic grant_if;
    logic grant_dm;

    // The DM request that was just rejected is still high while dm_gnt is visible;
    // masking it keeps an illegal store from being granted twice.
    assign dm_pending = dm_req & ~dm_gnt_q;
    assign dm_illegal = dm_write & (dm_write_type == 2'b10);

    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state_q == ST_IDLE) begin
            if (if_req && (!dm_pending || starve_force)) begin
                grant_if = 1'b1;
            end else if (dm_pending) begin
                grant_dm = 1'b1;
            end
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = (starve_cnt_q == 8'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_if) begin
            starve_cnt_d = 8'd0;
        end else if (grant_dm && !dm_illegal) begin
            if (!if_req) begin
                starve_cnt_d = 8'd0;
            end else if (starve_cnt_q != 8'hFF) begin
                starve_cnt_d = starve_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            starve_cnt_q <= 8'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned (no latch).
        state_d         = state_q;
        owner_d         = owner_q;
        if_gnt_d        = 1'b0;
        if_rvalid_d     = 1'b0;
        if_rdata_d      = if_rdata_q;
        dm_gnt_d        = 1'b0;
        dm_rvalid_d     = 1'b0;
        dm_rdata_d      = dm_rdata_q;
        dm_err_d        = 1'b0;
        l1_read_d       = l1_read_q;
        l1_write_d      = l1_write_q;
        l1_addr_d       = l1_addr_q;
        l1_write_type_d = l1_write_type_q;
        l1_write_data_d = l1_write_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_if) begin
                    if_gnt_d        = 1'b1;
                    owner_d         = OWN_IF;
                    state_d         = ST_ISSUE;
                    l1_read_d       = 1'b1;
                    l1_write_d      = 1'b0;
                    l1_addr_d       = if_addr;
                    l1_write_type_d = 2'b00;
                    l1_write_data_d = 32'd0;
                end else if (grant_dm) begin
                    dm_gnt_d = 1'b1;
                    if (dm_illegal) begin
                        dm_err_d = 1'b1;
                    end else begin
                        owner_d         = OWN_DM;
                        state_d         = ST_ISSUE;
                        l1_read_d       = ~dm_write;
                        l1_write_d      = dm_write;
                        l1_addr_d       = dm_addr;
                        l1_write_type_d = dm_write_type;
                        l1_write_data_d = dm_write_data;
                    end
                end
            end
            ST_ISSUE: begin
                if (l1_ready) begin
                    l1_read_d  = 1'b0;
                    l1_write_d = 1'b0;
                    state_d    = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (l1_resp_valid) begin
                    if (owner_q == OWN_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = l1_resp_data;
                    end else begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = l1_resp_data;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_IF;
            if_gnt_q        <= 1'b0;
            if_rvalid_q     <= 1'b0;
            if_rdata_q      <= 32'd0;
            dm_gnt_q        <= 1'b0;
            dm_rvalid_q     <= 1'b0;
            dm_rdata_q      <= 32'd0;
            dm_err_q        <= 1'b0;
            l1_read_q       <= 1'b0;
            l1_write_q      <= 1'b0;
            l1_addr_q       <= 32'd0;
            l1_write_type_q <= 2'b00;
            l1_write_data_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            if_gnt_q        <= if_gnt_d;
            if_rvalid_q     <= if_rvalid_d;
            if_rdata_q      <= if_rdata_d;
            dm_gnt_q        <= dm_gnt_d;
            dm_rvalid_q     <= dm_rvalid_d;
            dm_rdata_q      <= dm_rdata_d;
            dm_err_q        <= dm_err_d;
            l1_read_q       <= l1_read_d;
            l1_write_q      <= l1_write_d;
            l1_addr_q       <= l1_addr_d;
            l1_write_type_q <= l1_write_type_d;
            l1_write_data_q <= l1_write_data_d;
        end
    end

    assign if_gnt        = if_gnt_q;
    assign if_rvalid     = if_rvalid_q;
    assign if_rdata      = if_rdata_q;
    assign dm_gnt        = dm_gnt_q;
    assign dm_rvalid     = dm_rvalid_q;
    assign dm_rdata      = dm_rdata_q;
    assign dm_err        = dm_err_q;
    assign l1_read       = l1_read_q;
    assign l1_write      = l1_write_q;
    assign l1_addr       = l1_addr_q;
    assign l1_write_type = l1_write_type_q;
    assign l1_write_data = l1_write_data_q;

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Scoreboard bench for l1_port_arbiter: expected grants/responses are queued as stimulus
// is issued and compared when the DUT pulses gnt/rvalid. Build with ARB_STARVE_GUARD_EN to test the guard.
module tb_l1_port_arbiter;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [1:0]  dm_write_type;
    logic [31:0] dm_write_data;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic        l1_read;
    logic        l1_write;
    logic [31:0] l1_addr;
    logic [1:0]  l1_write_type;
    logic [31:0] l1_write_data;
    logic        l1_ready;
    logic        l1_resp_valid;
    logic [31:0] l1_resp_data;

    always #5 sys_clk = ~sys_clk;

    l1_port_arbiter #(.STARVE_LIMIT(2)) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_gnt        (if_gnt),
        .if_rvalid     (if_rvalid),
        .if_rdata      (if_rdata),
        .dm_req        (dm_req),
        .dm_write      (dm_write),
        .dm_addr       (dm_addr),
        .dm_write_type (dm_write_type),
        .dm_write_data (dm_write_data),
        .dm_gnt        (dm_gnt),
        .dm_rvalid     (dm_rvalid),
        .dm_rdata      (dm_rdata),
        .dm_err        (dm_err),
        .l1_read       (l1_read),
        .l1_write      (l1_write),
        .l1_addr       (l1_addr),
        .l1_write_type (l1_write_type),
        .l1_write_data (l1_write_data),
        .l1_ready      (l1_ready),
        .l1_resp_valid (l1_resp_valid),
        .l1_resp_data  (l1_resp_data)
    );

    typedef struct {
        logic        is_dm;
        logic        err;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  wtype;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        logic        is_dm;
        logic        chk_data;
        logic [31:0] data;
    } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    gnt_t cur_exp;
    gnt_t mon_e;
    rsp_t mon_r;
    logic busy = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int ready_wait = 0;
    int resp_wait  = 0;
    bit spurious   = 1'b0;
    bit l1_auto    = 1'b1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : {a[15:0], 16'hC0DE};
    endfunction

    function automatic gnt_t mk_if(input logic [31:0] a);
        gnt_t g;
        g = '{is_dm: 1'b0, err: 1'b0, rd: 1'b1, wr: 1'b0, addr: a, wtype: 2'b00, wdata: 32'd0};
        return g;
    endfunction

    function automatic gnt_t mk_dm(input logic w, input logic [31:0] a, input logic [1:0] t,
                                   input logic [31:0] d);
        gnt_t g;
        g = '{is_dm: 1'b1, err: 1'b0, rd: ~w, wr: w, addr: a, wtype: t, wdata: d};
        return g;
    endfunction

    // Monitor: sample away from the rising edge and compare against the queues.
    always @(negedge sys_clk) begin
        if (rst) begin
            busy = 1'b0;
        end else begin
            if (if_rvalid || dm_rvalid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("rvalid_owner", 32'({if_rvalid, dm_rvalid}), mon_r.is_dm ? 32'd1 : 32'd2);
                    if (mon_r.chk_data)
                        check("rdata", mon_r.is_dm ? dm_rdata : if_rdata, mon_r.data);
                end
                busy = 1'b0;
            end
            if (dm_err && !dm_gnt) check("err_without_gnt", 32'd1, 32'd0);
            if (if_gnt || dm_gnt) begin
                check("gnt_while_busy", 32'(busy), 32'd0);
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", 32'd1, 32'd0);
                end else begin
                    mon_e = gnt_q.pop_front();
                    check("gnt_owner", 32'({if_gnt, dm_gnt}), mon_e.is_dm ? 32'd1 : 32'd2);
                    check("gnt_err", 32'(dm_err), 32'(mon_e.err));
                    check("gnt_l1_rw", 32'({l1_read, l1_write}), 32'({mon_e.rd, mon_e.wr}));
                    if (!mon_e.err) begin
                        cur_exp = mon_e;
                        busy    = 1'b1;
                    end
                end
            end
            if ((l1_read || l1_write) && busy) begin
                check("l1_rw_hold", 32'({l1_read, l1_write}), 32'({cur_exp.rd, cur_exp.wr}));
                check("l1_addr", l1_addr, cur_exp.addr);
                check("l1_wtype", 32'(l1_write_type), 32'(cur_exp.wtype));
                check("l1_wdata", l1_write_data, cur_exp.wdata);
            end
        end
    end

    // L1 model: accepts after ready_wait cycles and answers resp_wait cycles later.
    initial begin
        l1_ready      = 1'b0;
        l1_resp_valid = 1'b0;
        l1_resp_data  = 32'd0;
        forever begin
            @(posedge sys_clk); #1;
            if (l1_auto && !rst && (l1_read || l1_write)) begin
                for (int i = 0; i < ready_wait; i++) begin
                    if (spurious && i == 1) begin
                        l1_resp_valid = 1'b1;
                        l1_resp_data  = 32'hBAD0_BAD0;
                    end
                    @(posedge sys_clk); #1;
                    l1_resp_valid = 1'b0;
                end
                l1_ready = 1'b1;
                @(posedge sys_clk); #1;
                l1_ready = 1'b0;
                for (int i = 0; i < resp_wait; i++) begin
                    @(posedge sys_clk); #1;
                end
                l1_resp_valid = 1'b1;
                l1_resp_data  = cur_exp.wr ? 32'h5707_E0AC : mem_word(cur_exp.addr);
                rsp_q.push_back('{is_dm: cur_exp.is_dm, chk_data: ~cur_exp.wr,
                                  data: mem_word(cur_exp.addr)});
                @(posedge sys_clk); #1;
                l1_resp_valid = 1'b0;
            end
        end
    end

    task automatic if_request(input logic [31:0] addr);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        if_req  = 1'b1;
        if_addr = addr;
        while (!got && n < 300) begin
            @(negedge sys_clk);
            got = if_gnt;
            n++;
        end
        if (!got) check("if_gnt_timeout", 32'd0, 32'd1);
        @(posedge sys_clk); #1;
        if_req  = 1'b0;
        if_addr = ~addr;
    endtask

    task automatic dm_request(input logic w, input logic [31:0] addr, input logic [1:0] t,
                              input logic [31:0] d);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        dm_req        = 1'b1;
        dm_write      = w;
        dm_addr       = addr;
        dm_write_type = t;
        dm_write_data = d;
        while (!got && n < 300) begin
            @(negedge sys_clk);
            got = dm_gnt;
            n++;
        end
        if (!got) check("dm_gnt_timeout", 32'd0, 32'd1);
        @(posedge sys_clk); #1;
        dm_req        = 1'b0;
        dm_addr       = ~addr;
        dm_write_data = ~d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || gnt_q.size() != 0) && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 300) check("idle_timeout", 32'd0, 32'd1);
        @(posedge sys_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_write = 1'b0; dm_addr = 32'd0; dm_write_type = 2'b00; dm_write_data = 32'd0;
        repeat (3) @(posedge sys_clk);
        #1 rst = 1'b0;
        @(negedge sys_clk);
        check("rst_ctrl", 32'({if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err, l1_read, l1_write, l1_write_type}), 32'd0);
        check("rst_l1_addr", l1_addr, 32'd0);
        check("rst_l1_wdata", l1_write_data, 32'd0);
        @(posedge sys_clk); #1;

        // IF read alone, 1-cycle issue, response two cycles after l1_ready.
        ready_wait = 0;
        resp_wait  = 1;
        gnt_q.push_back(mk_if(32'h40));
        if_request(32'h40);
        wait_idle();

        // Simultaneous: DM store first, IF afterwards.
        gnt_q.push_back(mk_dm(1'b1, 32'h100, 2'b11, 32'h1234_5678));
        gnt_q.push_back(mk_if(32'h200));
        fork
            dm_request(1'b1, 32'h100, 2'b11, 32'h1234_5678);
            if_request(32'h200);
        join
        wait_idle();

        // Back-pressure with a spurious response during ISSUE.
        ready_wait = 5;
        spurious   = 1'b1;
        resp_wait  = 0;
        gnt_q.push_back(mk_dm(1'b0, 32'h80, 2'b00, 32'd0));
        dm_request(1'b0, 32'h80, 2'b00, 32'd0);
        wait_idle();
        ready_wait = 0;
        spurious   = 1'b0;

        // Illegal store rejected, then IF served straight from IDLE; then a halfword store.
        gnt_q.push_back('{is_dm: 1'b1, err: 1'b1, rd: 1'b0, wr: 1'b0, addr: 32'd0, wtype: 2'b00, wdata: 32'd0});
        gnt_q.push_back(mk_if(32'h44));
        fork
            dm_request(1'b1, 32'h120, 2'b10, 32'h0000_AAAA);
            if_request(32'h44);
        join
        wait_idle();
        gnt_q.push_back(mk_dm(1'b1, 32'h124, 2'b01, 32'h0000_BEEF));
        dm_request(1'b1, 32'h124, 2'b01, 32'h0000_BEEF);
        wait_idle();

        // Reset while waiting for the response; the late response must be ignored.
        l1_auto = 1'b0;
        gnt_q.push_back(mk_if(32'h500));
        if_request(32'h500);
        l1_ready = 1'b1;
        @(posedge sys_clk); #1;
        l1_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b0;
        @(negedge sys_clk);
        check("midrst_ctrl", 32'({if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err, l1_read, l1_write, l1_write_type}), 32'd0);
        check("midrst_l1_addr", l1_addr, 32'd0);
        check("midrst_if_rdata", if_rdata, 32'd0);
        check("midrst_dm_rdata", dm_rdata, 32'd0);
        @(posedge sys_clk); #1;
        l1_resp_valid = 1'b1;
        l1_resp_data  = 32'hFEED_F00D;
        @(posedge sys_clk); #1;
        l1_resp_valid = 1'b0;
        @(negedge sys_clk);
        check("rvalid_after_rst", 32'({if_rvalid, dm_rvalid}), 32'd0);
        @(posedge sys_clk); #1;
        l1_auto = 1'b1;

        // Both requesters continuous.
`ifdef ARB_STARVE_GUARD_EN
        gnt_q.push_back(mk_dm(1'b0, 32'h300, 2'b00, 32'd0));
        gnt_q.push_back(mk_dm(1'b0, 32'h304, 2'b00, 32'd0));
        gnt_q.push_back(mk_if(32'h400));
        gnt_q.push_back(mk_dm(1'b0, 32'h308, 2'b00, 32'd0));
        gnt_q.push_back(mk_dm(1'b0, 32'h30C, 2'b00, 32'd0));
        gnt_q.push_back(mk_if(32'h404));
`else
        gnt_q.push_back(mk_dm(1'b0, 32'h300, 2'b00, 32'd0));
        gnt_q.push_back(mk_dm(1'b0, 32'h304, 2'b00, 32'd0));
        gnt_q.push_back(mk_dm(1'b0, 32'h308, 2'b00, 32'd0));
        gnt_q.push_back(mk_dm(1'b0, 32'h30C, 2'b00, 32'd0));
        gnt_q.push_back(mk_if(32'h400));
        gnt_q.push_back(mk_if(32'h404));
`endif
        fork
            begin
                for (int k = 0; k < 4; k++) dm_request(1'b0, 32'h300 + 32'(4 * k), 2'b00, 32'd0);
            end
            begin
                for (int k = 0; k < 2; k++) if_request(32'h400 + 32'(4 * k));
            end
        join
        wait_idle();

        repeat (5) @(posedge sys_clk);
        check("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
